vip_csc_binarize: RTL and testbench

VIP_CSC_BINARIZE -- requirements
Module: vip_csc_binarize

---
 rtl/vip_csc_binarize.sv | 223 ++++++++++++++++++++++
 tb/tb_vip_csc_binarize.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_csc_binarize.sv
// RGB -> YCbCr converter with per-frame mode/threshold latching and Y binarisation.
// Three-stage pipeline: products, sums, then shift/saturate/mode select.
module vip_csc_binarize #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned THRESH_RST = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [3:0]        per_img_mode,
  input  logic [DATA_W-1:0] per_bin_thresh,
  input  logic [DATA_W-1:0] per_img_red,
  input  logic [DATA_W-1:0] per_img_green,
  input  logic [DATA_W-1:0] per_img_blue,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [3:0]        post_img_mode,
  output logic [DATA_W-1:0] post_img_Y,
  output logic [DATA_W-1:0] post_img_Cb,
  output logic [DATA_W-1:0] post_img_Cr,
  output logic              post_img_bit
);

  localparam int unsigned W = DATA_W + 10;

  localparam logic signed [W-1:0] OFF  = $signed(W'(1) << (DATA_W + 7));
  localparam logic signed [W-1:0] C21  = W'(21);
  localparam logic signed [W-1:0] C29  = W'(29);
  localparam logic signed [W-1:0] C43  = W'(43);
  localparam logic signed [W-1:0] C77  = W'(77);
  localparam logic signed [W-1:0] C85  = W'(85);
  localparam logic signed [W-1:0] C107 = W'(107);
  localparam logic signed [W-1:0] C128 = W'(128);
  localparam logic signed [W-1:0] C150 = W'(150);

  localparam logic [DATA_W-1:0] MAXV = '1;
  localparam logic [DATA_W-1:0] HALF = DATA_W'(1) << (DATA_W - 1);

  // Shift the weighted sum back to pixel scale and clamp to [0, MAXV].
  function automatic logic [DATA_W-1:0] sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] s;
    s = v >>> 8;
    if (s[W-1])
      return '0;
    else if (|s[W-2:DATA_W])
      return MAXV;
    else
      return s[DATA_W-1:0];
  endfunction

  // Frame tracking and per-frame parameter latches
  logic              vsync_d;
  logic [3:0]        mode_q;
  logic [DATA_W-1:0] thresh_q;

  logic              fs_c;
  logic [3:0]        mode_raw_c;
  logic [1:0]        mode_c;
  logic [DATA_W-1:0] thresh_c;

  // Stage 1
  logic signed [W-1:0] p_yr, p_yg, p_yb;
  logic signed [W-1:0] p_cbr, p_cbg, p_cbb;
  logic signed [W-1:0] p_crr, p_crg, p_crb;
  logic [DATA_W-1:0]   r_s1, g_s1, b_s1, thresh_s1;
  logic [1:0]          mode_s1;
  logic                vs_s1, hs_s1, ck_s1;

  // Stage 2
  logic signed [W-1:0] y_sum, cb_sum, cr_sum;
  logic [DATA_W-1:0]   r_s2, g_s2, b_s2, thresh_s2;
  logic [1:0]          mode_s2;
  logic                vs_s2, hs_s2, ck_s2;

  // Stage 3 combinational results
  logic [DATA_W-1:0] y_c, cb_c, cr_c;
  logic [DATA_W-1:0] y_sel_c, cb_sel_c, cr_sel_c;
  logic              bit_c;

  // The frame-start pixel uses the live request; later pixels use the latched one.
  always_comb begin
    fs_c       = per_frame_vsync & ~vsync_d;
    mode_raw_c = fs_c ? per_img_mode   : mode_q;
    thresh_c   = fs_c ? per_bin_thresh : thresh_q;
    mode_c     = (mode_raw_c > 4'd3) ? 2'd0 : mode_raw_c[1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d  <= 1'b0;
      mode_q   <= '0;
      thresh_q <= DATA_W'(THRESH_RST);
    end else begin
      vsync_d <= per_frame_vsync;
      if (fs_c) begin
        mode_q   <= per_img_mode;
        thresh_q <= per_bin_thresh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_yr      <= '0;
      p_yg      <= '0;
      p_yb      <= '0;
      p_cbr     <= '0;
      p_cbg     <= '0;
      p_cbb     <= '0;
      p_crr     <= '0;
      p_crg     <= '0;
      p_crb     <= '0;
      r_s1      <= '0;
      g_s1      <= '0;
      b_s1      <= '0;
      thresh_s1 <= '0;
      mode_s1   <= '0;
      vs_s1     <= 1'b0;
      hs_s1     <= 1'b0;
      ck_s1     <= 1'b0;
    end else begin
      p_yr      <= $signed(W'(per_img_red))   * C77;
      p_yg      <= $signed(W'(per_img_green)) * C150;
      p_yb      <= $signed(W'(per_img_blue))  * C29;
      p_cbr     <= $signed(W'(per_img_red))   * C43;
      p_cbg     <= $signed(W'(per_img_green)) * C85;
      p_cbb     <= $signed(W'(per_img_blue))  * C128;
      p_crr     <= $signed(W'(per_img_red))   * C128;
      p_crg     <= $signed(W'(per_img_green)) * C107;
      p_crb     <= $signed(W'(per_img_blue))  * C21;
      r_s1      <= per_img_red;
      g_s1      <= per_img_green;
      b_s1      <= per_img_blue;
      thresh_s1 <= thresh_c;
      mode_s1   <= mode_c;
      vs_s1     <= per_frame_vsync;
      hs_s1     <= per_frame_href;
      ck_s1     <= per_frame_clken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_sum     <= '0;
      cb_sum    <= '0;
      cr_sum    <= '0;
      r_s2      <= '0;
      g_s2      <= '0;
      b_s2      <= '0;
      thresh_s2 <= '0;
      mode_s2   <= '0;
      vs_s2     <= 1'b0;
      hs_s2     <= 1'b0;
      ck_s2     <= 1'b0;
    end else begin
      y_sum     <= p_yr + p_yg + p_yb;
      cb_sum    <= p_cbb - p_cbr - p_cbg + OFF;
      cr_sum    <= p_crr - p_crg - p_crb + OFF;
      r_s2      <= r_s1;
      g_s2      <= g_s1;
      b_s2      <= b_s1;
      thresh_s2 <= thresh_s1;
      mode_s2   <= mode_s1;
      vs_s2     <= vs_s1;
      hs_s2     <= hs_s1;
      ck_s2     <= ck_s1;
    end
  end

  // Saturate, binarise and pick the component set for the active mode.
  always_comb begin
    y_c      = sat(y_sum);
    cb_c     = sat(cb_sum);
    cr_c     = sat(cr_sum);
    bit_c    = (y_c > thresh_s2);
    y_sel_c  = y_c;
    cb_sel_c = cb_c;
    cr_sel_c = cr_c;
    case (mode_s2)
      2'd1: begin
        y_sel_c  = r_s2;
        cb_sel_c = g_s2;
        cr_sel_c = b_s2;
      end
      2'd2: begin
        cb_sel_c = HALF;
        cr_sel_c = HALF;
      end
      2'd3: begin
        y_sel_c  = bit_c ? MAXV : '0;
        cb_sel_c = bit_c ? MAXV : '0;
        cr_sel_c = bit_c ? MAXV : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_mode    <= '0;
      post_img_Y       <= '0;
      post_img_Cb      <= '0;
      post_img_Cr      <= '0;
      post_img_bit     <= 1'b0;
    end else begin
      post_frame_vsync <= vs_s2;
      post_frame_href  <= hs_s2;
      post_frame_clken <= ck_s2;
      post_img_mode    <= 4'(mode_s2);
      post_img_Y       <= hs_s2 ? y_sel_c  : '0;
      post_img_Cb      <= hs_s2 ? cb_sel_c : '0;
      post_img_Cr      <= hs_s2 ? cr_sel_c : '0;
      post_img_bit     <= hs_s2 & bit_c;
    end
  end

endmodule

// File: tb/tb_vip_csc_binarize.sv
// Bench for vip_csc_binarize: directed literal checks plus a randomized run
// compared every cycle against a behavioural model of the converter.
module tb_vip_csc_binarize;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          per_frame_vsync, per_frame_href, per_frame_clken;
  logic [3:0]    per_img_mode;
  logic [DW-1:0] per_bin_thresh;
  logic [DW-1:0] per_img_red, per_img_green, per_img_blue;
  logic          post_frame_vsync, post_frame_href, post_frame_clken;
  logic [3:0]    post_img_mode;
  logic [DW-1:0] post_img_Y, post_img_Cb, post_img_Cr;
  logic          post_img_bit;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vip_csc_binarize #(.DATA_W(DW), .THRESH_RST(128)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_mode     (per_img_mode),
    .per_bin_thresh   (per_bin_thresh),
    .per_img_red      (per_img_red),
    .per_img_green    (per_img_green),
    .per_img_blue     (per_img_blue),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_mode    (post_img_mode),
    .post_img_Y       (post_img_Y),
    .post_img_Cb      (post_img_Cb),
    .post_img_Cr      (post_img_Cr),
    .post_img_bit     (post_img_bit)
  );

  typedef struct {
    bit vs, hs, ck;
    int mode, y, cb, cr;
    bit b;
  } exp_t;

  function automatic int sat_i(int v);
    int maxv = (1 << DW) - 1;
    if (v < 0) return 0;
    if (v > maxv) return maxv;
    return v;
  endfunction

  // Expected output of one pixel, straight from the conversion formulas.
  function automatic exp_t model_px(int r, int g, int b, int mode, int thr,
                                    bit vs, bit hs, bit ck);
    exp_t e;
    int maxv = (1 << DW) - 1;
    int half = 1 << (DW - 1);
    int y, cb, cr, m;
    y  = sat_i((77 * r + 150 * g + 29 * b) >>> 8);
    cb = sat_i((-43 * r - 85 * g + 128 * b + half * 256) >>> 8);
    cr = sat_i((128 * r - 107 * g - 21 * b + half * 256) >>> 8);
    m  = (mode > 3) ? 0 : mode;
    e.vs = vs; e.hs = hs; e.ck = ck; e.mode = m;
    e.b  = (y > thr);
    case (m)
      1:       begin e.y = r; e.cb = g;    e.cr = b;    end
      2:       begin e.y = y; e.cb = half; e.cr = half; end
      3:       begin e.y = e.b ? maxv : 0; e.cb = e.y; e.cr = e.y; end
      default: begin e.y = y; e.cb = cb;   e.cr = cr;   end
    endcase
    if (!hs) begin e.y = 0; e.cb = 0; e.cr = 0; e.b = 0; end
    return e;
  endfunction

  function automatic exp_t zero_e();
    exp_t e;
    e.vs = 0; e.hs = 0; e.ck = 0; e.mode = 0; e.y = 0; e.cb = 0; e.cr = 0; e.b = 0;
    return e;
  endfunction

  exp_t pipe [3];
  int   mode_m, thresh_m;
  bit   vs_prev;
  bit   chk_en = 1'b0;

  // Reference model: per-frame latching and a three-deep latency queue.
  always @(posedge clk) begin : model
    exp_t e;
    bit   fs;
    int   em, et;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] <= zero_e();
      mode_m   <= 0;
      thresh_m <= 128;
      vs_prev  <= 1'b0;
      chk_en   <= 1'b1;
    end else begin
      fs = per_frame_vsync && !vs_prev;
      em = fs ? int'(per_img_mode) : mode_m;
      et = fs ? int'(per_bin_thresh) : thresh_m;
      e  = model_px(int'(per_img_red), int'(per_img_green), int'(per_img_blue),
                    em, et, per_frame_vsync, per_frame_href, per_frame_clken);
      pipe[0] <= e;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      if (fs) begin
        mode_m   <= int'(per_img_mode);
        thresh_m <= int'(per_bin_thresh);
      end
      vs_prev <= per_frame_vsync;
    end
  end

  always @(negedge clk) begin : scoreboard
    if (chk_en) begin
      n_tests++;
      if (post_frame_vsync !== pipe[2].vs || post_frame_href !== pipe[2].hs ||
          post_frame_clken !== pipe[2].ck || post_img_mode !== 4'(pipe[2].mode) ||
          post_img_Y !== DW'(pipe[2].y) || post_img_Cb !== DW'(pipe[2].cb) ||
          post_img_Cr !== DW'(pipe[2].cr) || post_img_bit !== pipe[2].b) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got vs/hs/ck=%b%b%b mode=%0d Y=%0d Cb=%0d Cr=%0d bit=%b expected %b%b%b mode=%0d Y=%0d Cb=%0d Cr=%0d bit=%b",
                 $time, post_frame_vsync, post_frame_href, post_frame_clken, post_img_mode,
                 post_img_Y, post_img_Cb, post_img_Cr, post_img_bit,
                 pipe[2].vs, pipe[2].hs, pipe[2].ck, pipe[2].mode,
                 pipe[2].y, pipe[2].cb, pipe[2].cr, pipe[2].b);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic px(int r, int g, int b);
    per_img_red   = DW'(r);
    per_img_green = DW'(g);
    per_img_blue  = DW'(b);
  endtask

  task automatic chk_pix(string name, int y, int cb, int cr, int b, int mode);
    chk({name, ".Y"},    32'(post_img_Y),    32'(y));
    chk({name, ".Cb"},   32'(post_img_Cb),   32'(cb));
    chk({name, ".Cr"},   32'(post_img_Cr),   32'(cr));
    chk({name, ".bit"},  32'(post_img_bit),  32'(b));
    chk({name, ".mode"}, 32'(post_img_mode), 32'(mode));
  endtask

  initial begin
    int vs_cnt;
    int v;
    rst_n = 1'b0;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
    per_img_mode = 4'd0; per_bin_thresh = DW'(128);
    px(0, 0, 0);
    repeat (2) cyc();
    chk_pix("reset", 0, 0, 0, 0, 0);
    chk("reset.clken", 32'(post_frame_clken), 0);
    chk("reset.vsync", 32'(post_frame_vsync), 0);
    rst_n = 1'b1;

    per_frame_vsync = 1'b1; per_frame_href = 1'b1; per_frame_clken = 1'b1;
    px(255, 255, 255);
    repeat (3) cyc();
    chk_pix("white", 255, 128, 128, 1, 0);
    chk("white.clken", 32'(post_frame_clken), 1);

    px(255, 0, 0);
    repeat (3) cyc();
    chk_pix("red", 76, 85, 255, 0, 0);

    // Gray frame; the mode request changes right after frame start.
    per_frame_vsync = 1'b0;
    cyc();
    per_frame_vsync = 1'b1; per_img_mode = 4'd2;
    px(0, 0, 255);
    cyc();
    per_img_mode = 4'd0;
    repeat (2) cyc();
    chk_pix("latch_first", 28, 128, 128, 0, 2);
    repeat (3) cyc();
    chk_pix("latch_mid", 28, 128, 128, 0, 2);

    // One-cycle vsync gap still starts a new frame.
    per_frame_vsync = 1'b0;
    cyc();
    per_frame_vsync = 1'b1;
    repeat (3) cyc();
    chk_pix("next_frame", 28, 255, 107, 0, 0);

    per_frame_vsync = 1'b0;
    cyc();
    per_frame_vsync = 1'b1; per_img_mode = 4'd3; per_bin_thresh = DW'(100);
    px(200, 200, 200);
    repeat (3) cyc();
    chk_pix("bin_high", 255, 255, 255, 1, 3);
    px(100, 100, 100);
    repeat (3) cyc();
    chk_pix("bin_equal", 0, 0, 0, 0, 3);

    per_frame_href = 1'b0; per_frame_clken = 1'b0;
    px(255, 255, 255);
    repeat (3) cyc();
    chk_pix("href_gate", 0, 0, 0, 0, 3);
    chk("href_gate.vsync", 32'(post_frame_vsync), 1);
    chk("href_gate.href",  32'(post_frame_href), 0);

    // Reset during a burst, then no stale clken and threshold back at 128.
    per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_mode = 4'd0;
    for (int i = 0; i < 4; i++) begin
      px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    chk_pix("mid_reset", 0, 0, 0, 0, 0);
    chk("mid_reset.clken", 32'(post_frame_clken), 0);
    chk("mid_reset.href",  32'(post_frame_href), 0);
    chk("mid_reset.vsync", 32'(post_frame_vsync), 0);
    rst_n = 1'b1;
    per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_reset.clken", 32'(post_frame_clken), 0);
    end
    per_frame_href = 1'b1; per_frame_clken = 1'b1;
    px(129, 129, 129);
    repeat (3) cyc();
    chk_pix("thresh_rst_above", 129, 128, 128, 1, 0);
    px(128, 128, 128);
    repeat (3) cyc();
    chk_pix("thresh_rst_equal", 128, 128, 128, 0, 0);

    // Randomized frames with short vsync gaps, clken gaps and rare resets.
    vs_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (vs_cnt == 0) begin
        per_frame_vsync = ~per_frame_vsync;
        vs_cnt = per_frame_vsync ? int'($urandom_range(20, 150)) : int'($urandom_range(1, 3));
      end
      vs_cnt--;
      per_frame_href  = ($urandom_range(0, 3) != 0);
      per_frame_clken = per_frame_href ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 7) == 0);
      per_img_mode    = 4'($urandom_range(0, 15));
      per_bin_thresh  = DW'($urandom_range(0, 255));
      v = int'($urandom_range(0, 3));
      if (v == 0)      px(0, 0, 0);
      else if (v == 1) px(255, 255, 255);
      else             px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end
    rst_n = 1'b1;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
